// File: rtl/camera_seq_pkg.sv
// Shared types and default timing for the camera sensor power sequencer.
// Default timings assume clk_25M = 25 MHz.
package camera_seq_pkg;

  typedef enum logic [2:0] {
    S_PWDN  = 3'd0,
    S_RST   = 3'd1,
    S_WAIT  = 3'd2,
    S_CFG   = 3'd3,
    S_READY = 3'd4,
    S_FAIL  = 3'd5
  } state_t;

  localparam int TIMER_W         = 26;
  localparam int T_PWDN_DEF      = 125000;    // 5 ms
  localparam int T_RST_DEF       = 25000;     // 1 ms
  localparam int T_INIT_DEF      = 500000;    // 20 ms
  localparam int CFG_TIMEOUT_DEF = 50000000;  // 2 s
  localparam int MAX_RETRY_DEF   = 3;

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter shared by every timed sequencer state.
// expire is high for the single cycle the count sits at 1, so a state loaded with N lasts N cycles.
module seq_timer
  import camera_seq_pkg::*;
#(
  parameter logic [TIMER_W-1:0] RST_VAL = '0
) (
  input  logic               clk_25M,
  input  logic               camera_rstn,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expire
);

  localparam logic [TIMER_W-1:0] ONE = TIMER_W'(1);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = load_val;
    else if (count_q != '0)
      count_d = count_q - ONE;
  end

  always_ff @(posedge clk_25M or negedge camera_rstn) begin
    if (!camera_rstn) count_q <= RST_VAL;
    else              count_q <= count_d;
  end

  assign expire = (count_q == ONE);

endmodule

// File: rtl/camera_power_seq.sv
// Camera sensor power-up sequencer: PWDN hold, RESETB low, settle, then register configuration.
// Define CAM_SEQ_TIMEOUT_EN to enable the cfg_done timeout with re-power retries and S_FAIL.
module camera_power_seq
  import camera_seq_pkg::*;
#(
  parameter int T_PWDN_CYC      = T_PWDN_DEF,
  parameter int T_RST_CYC       = T_RST_DEF,
  parameter int T_INIT_CYC      = T_INIT_DEF,
  parameter int CFG_TIMEOUT_CYC = CFG_TIMEOUT_DEF,
  parameter int MAX_RETRY       = MAX_RETRY_DEF
) (
  input  logic       clk_25M,
  input  logic       camera_rstn,
  input  logic       soft_restart,
  input  logic       cfg_done,
  output logic       cam_pwdn,
  output logic       cam_resetb,
  output logic       cfg_rstn,
  output logic       initial_en,
  output logic       seq_ready,
  output logic       seq_fail,
  output logic [1:0] retry_cnt
);

  localparam logic [TIMER_W-1:0] LD_PWDN = TIMER_W'(T_PWDN_CYC);
  localparam logic [TIMER_W-1:0] LD_RST  = TIMER_W'(T_RST_CYC);
  localparam logic [TIMER_W-1:0] LD_INIT = TIMER_W'(T_INIT_CYC);
  localparam logic [TIMER_W-1:0] LD_CFG  = TIMER_W'(CFG_TIMEOUT_CYC);

  state_t             state_q, state_d;
  logic [1:0]         retry_q, retry_d;
  logic [1:0]         cfg_sync_q, cfg_sync_d;
  logic               load, expire, cfg_timeout;
  logic [TIMER_W-1:0] load_val;
  logic               cam_pwdn_q, cam_pwdn_d, cam_resetb_q, cam_resetb_d;
  logic               cfg_rstn_q, cfg_rstn_d, initial_en_q, initial_en_d;
  logic               seq_ready_q, seq_ready_d, seq_fail_q, seq_fail_d;

  seq_timer #(.RST_VAL(LD_PWDN)) u_timer (
    .clk_25M     (clk_25M),
    .camera_rstn (camera_rstn),
    .load        (load),
    .load_val    (load_val),
    .expire      (expire)
  );

  // With the timeout disabled retry_q and S_FAIL can never be reached, so both outputs stay 0.
`ifdef CAM_SEQ_TIMEOUT_EN
  assign cfg_timeout = expire;
`else
  assign cfg_timeout = 1'b0;
`endif

  always_ff @(posedge clk_25M or negedge camera_rstn) begin
    if (!camera_rstn) begin
      state_q      <= S_PWDN;
      retry_q      <= '0;
      cfg_sync_q   <= '0;
      cam_pwdn_q   <= 1'b1;
      cam_resetb_q <= 1'b0;
      cfg_rstn_q   <= 1'b0;
      initial_en_q <= 1'b0;
      seq_ready_q  <= 1'b0;
      seq_fail_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      cfg_sync_q   <= cfg_sync_d;
      cam_pwdn_q   <= cam_pwdn_d;
      cam_resetb_q <= cam_resetb_d;
      cfg_rstn_q   <= cfg_rstn_d;
      initial_en_q <= initial_en_d;
      seq_ready_q  <= seq_ready_d;
      seq_fail_q   <= seq_fail_d;
    end
  end

  // Every transition into a timed state reloads the timer, including re-entry of S_PWDN.
  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    load       = 1'b0;
    cfg_sync_d = {cfg_sync_q[0], cfg_done};
    if (soft_restart) begin
      state_d = S_PWDN;
      retry_d = '0;
      load    = 1'b1;
    end else begin
      case (state_q)
        S_PWDN: if (expire) begin state_d = S_RST;  load = 1'b1; end
        S_RST:  if (expire) begin state_d = S_WAIT; load = 1'b1; end
        S_WAIT: if (expire) begin state_d = S_CFG;  load = 1'b1; end
        S_CFG: begin
          if (cfg_sync_q[1]) begin
            state_d = S_READY;
          end else if (cfg_timeout) begin
            if (int'(retry_q) < MAX_RETRY) begin
              state_d = S_PWDN;
              load    = 1'b1;
              if (retry_q != 2'd3) retry_d = retry_q + 2'd1;
            end else begin
              state_d = S_FAIL;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    cam_pwdn_d   = 1'b1;
    cam_resetb_d = 1'b0;
    cfg_rstn_d   = 1'b0;
    initial_en_d = 1'b0;
    seq_ready_d  = 1'b0;
    seq_fail_d   = 1'b0;
    load_val     = '0;
    case (state_d)
      S_PWDN: load_val = LD_PWDN;
      S_RST: begin
        cam_pwdn_d = 1'b0;
        load_val   = LD_RST;
      end
      S_WAIT: begin
        cam_pwdn_d   = 1'b0;
        cam_resetb_d = 1'b1;
        load_val     = LD_INIT;
      end
      S_CFG, S_READY: begin
        cam_pwdn_d   = 1'b0;
        cam_resetb_d = 1'b1;
        cfg_rstn_d   = 1'b1;
        initial_en_d = 1'b1;
        seq_ready_d  = (state_d == S_READY);
        load_val     = LD_CFG;
      end
      S_FAIL: seq_fail_d = 1'b1;
      default: ;
    endcase
  end

  assign cam_pwdn   = cam_pwdn_q;
  assign cam_resetb = cam_resetb_q;
  assign cfg_rstn   = cfg_rstn_q;
  assign initial_en = initial_en_q;
  assign seq_ready  = seq_ready_q;
  assign seq_fail   = seq_fail_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_camera_power_seq.sv
// Directed bench for camera_power_seq with shortened timings (10/5/20/50 cycles, 2 retries).
// Timeout scenarios run only when CAM_SEQ_TIMEOUT_EN is defined; otherwise the no-timeout case runs.
module tb_camera_power_seq;

  logic       clk_25M = 1'b0;
  logic       camera_rstn = 1'b0;
  logic       soft_restart = 1'b0;
  logic       cfg_done = 1'b0;
  logic       cam_pwdn, cam_resetb, cfg_rstn, initial_en, seq_ready, seq_fail;
  logic [1:0] retry_cnt;
  logic [7:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  // {pwdn, resetb, cfg_rstn, initial_en, seq_ready, seq_fail, retry_cnt[1:0]}
  localparam logic [7:0] O_PWDN  = 8'b1000_0000;
  localparam logic [7:0] O_RST   = 8'b0000_0000;
  localparam logic [7:0] O_WAIT  = 8'b0100_0000;
  localparam logic [7:0] O_CFG   = 8'b0111_0000;
  localparam logic [7:0] O_READY = 8'b0111_1000;
  localparam logic [7:0] O_FAIL  = 8'b1000_0100;

  camera_power_seq #(
    .T_PWDN_CYC      (10),
    .T_RST_CYC       (5),
    .T_INIT_CYC      (20),
    .CFG_TIMEOUT_CYC (50),
    .MAX_RETRY       (2)
  ) dut (
    .clk_25M      (clk_25M),
    .camera_rstn  (camera_rstn),
    .soft_restart (soft_restart),
    .cfg_done     (cfg_done),
    .cam_pwdn     (cam_pwdn),
    .cam_resetb   (cam_resetb),
    .cfg_rstn     (cfg_rstn),
    .initial_en   (initial_en),
    .seq_ready    (seq_ready),
    .seq_fail     (seq_fail),
    .retry_cnt    (retry_cnt)
  );

  assign outs = {cam_pwdn, cam_resetb, cfg_rstn, initial_en, seq_ready, seq_fail, retry_cnt};

  always #20 clk_25M = ~clk_25M;

  // Expected outputs k edges after entering S_PWDN with no cfg_done and no timeout yet.
  function automatic logic [7:0] exp_seq(input int k, input logic [1:0] r);
    logic [7:0] v;
    if (k < 10)      v = O_PWDN;
    else if (k < 15) v = O_RST;
    else if (k < 35) v = O_WAIT;
    else             v = O_CFG;
    return v | {6'b0, r};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_25M);
      #1;
    end
  endtask

  // Leaves the bench just before edge 1 after reset release.
  task automatic do_reset();
    camera_rstn  = 1'b0;
    soft_restart = 1'b0;
    cfg_done     = 1'b0;
    @(negedge clk_25M);
    @(negedge clk_25M);
    camera_rstn = 1'b1;
  endtask

  task automatic test_reset();
    camera_rstn = 1'b0;
    cfg_done    = 1'b1;
    tick(3);
    n_checks++;
    if (outs !== O_PWDN) begin
      n_fail++;
      $display("FAIL reset_values: got %b expected %b", outs, O_PWDN);
    end
    cfg_done = 1'b0;
  endtask

  task automatic test_power_up();
    logic [7:0] exp;
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      exp = exp_seq(k, 2'd0);
      n_checks++;
      if (outs !== exp) begin
        n_fail++;
        $display("FAIL power_up edge %0d: got %b expected %b", k, outs, exp);
      end
    end
  endtask

  task automatic test_cfg_ready();
    do_reset();
    tick(47);
    cfg_done = 1'b1;
    tick(2);
    n_checks++;
    if (outs !== O_CFG) begin
      n_fail++;
      $display("FAIL cfg_ready_early edge 49: got %b expected %b", outs, O_CFG);
    end
    tick(1);
    n_checks++;
    if (outs !== O_READY) begin
      n_fail++;
      $display("FAIL cfg_ready_rise edge 50: got %b expected %b", outs, O_READY);
    end
    for (int i = 0; i < 10; i++) begin
      cfg_done = ~cfg_done;
      tick(1);
      n_checks++;
      if (outs !== O_READY) begin
        n_fail++;
        $display("FAIL ready_hold toggle %0d: got %b expected %b", i, outs, O_READY);
      end
    end
    tick(40);
    n_checks++;
    if (outs !== O_READY) begin
      n_fail++;
      $display("FAIL ready_past_timeout: got %b expected %b", outs, O_READY);
    end
  endtask

  task automatic test_soft_restart_ready();
    logic [7:0] exp;
    cfg_done     = 1'b0;
    soft_restart = 1'b1;
    tick(1);
    soft_restart = 1'b0;
    n_checks++;
    if (outs !== O_PWDN) begin
      n_fail++;
      $display("FAIL restart_from_ready: got %b expected %b", outs, O_PWDN);
    end
    for (int k = 1; k <= 36; k++) begin
      tick(1);
      exp = exp_seq(k, 2'd0);
      n_checks++;
      if (outs !== exp) begin
        n_fail++;
        $display("FAIL restart_seq edge %0d: got %b expected %b", k, outs, exp);
      end
    end
  endtask

  task automatic test_cfg_done_ignored();
    do_reset();
    cfg_done = 1'b1;
    tick(10);
    n_checks++;
    if (outs !== O_RST) begin
      n_fail++;
      $display("FAIL ignored_in_pwdn edge 10: got %b expected %b", outs, O_RST);
    end
    tick(25);
    n_checks++;
    if (outs !== O_CFG) begin
      n_fail++;
      $display("FAIL ignored_in_wait edge 35: got %b expected %b", outs, O_CFG);
    end
    tick(1);
    n_checks++;
    if (outs !== O_READY) begin
      n_fail++;
      $display("FAIL ready_first_cfg edge 36: got %b expected %b", outs, O_READY);
    end
    cfg_done = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(12);
    n_checks++;
    if (outs !== O_RST) begin
      n_fail++;
      $display("FAIL async_pre edge 12: got %b expected %b", outs, O_RST);
    end
    #2 camera_rstn = 1'b0;
    #1;
    n_checks++;
    if (outs !== O_PWDN) begin
      n_fail++;
      $display("FAIL async_abort: got %b expected %b", outs, O_PWDN);
    end
    @(negedge clk_25M);
    camera_rstn = 1'b1;
    tick(9);
    n_checks++;
    if (outs !== O_PWDN) begin
      n_fail++;
      $display("FAIL async_restart edge 9: got %b expected %b", outs, O_PWDN);
    end
    tick(1);
    n_checks++;
    if (outs !== O_RST) begin
      n_fail++;
      $display("FAIL async_restart edge 10: got %b expected %b", outs, O_RST);
    end
  endtask

`ifdef CAM_SEQ_TIMEOUT_EN
  task automatic test_timeout_retry();
    logic [7:0] exp [6];
    int         at  [6];
    at[0] = 84;  exp[0] = O_CFG;
    at[1] = 85;  exp[1] = O_PWDN | 8'd1;
    at[2] = 95;  exp[2] = O_RST  | 8'd1;
    at[3] = 170; exp[3] = O_PWDN | 8'd2;
    at[4] = 254; exp[4] = O_CFG  | 8'd2;
    at[5] = 255; exp[5] = O_FAIL | 8'd2;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(at[i] - ((i == 0) ? 0 : at[i-1]));
      n_checks++;
      if (outs !== exp[i]) begin
        n_fail++;
        $display("FAIL timeout_retry edge %0d: got %b expected %b", at[i], outs, exp[i]);
      end
    end
    tick(20);
    n_checks++;
    if (outs !== (O_FAIL | 8'd2)) begin
      n_fail++;
      $display("FAIL fail_sticky: got %b expected %b", outs, O_FAIL | 8'd2);
    end
  endtask

  task automatic test_soft_restart_fail();
    logic [7:0] exp;
    soft_restart = 1'b1;
    tick(1);
    soft_restart = 1'b0;
    n_checks++;
    if (outs !== O_PWDN) begin
      n_fail++;
      $display("FAIL restart_from_fail: got %b expected %b", outs, O_PWDN);
    end
    for (int k = 1; k <= 35; k++) begin
      tick(1);
      exp = exp_seq(k, 2'd0);
      n_checks++;
      if (outs !== exp) begin
        n_fail++;
        $display("FAIL fail_restart_seq edge %0d: got %b expected %b", k, outs, exp);
      end
    end
  endtask

  task automatic test_coincide();
    do_reset();
    tick(82);
    cfg_done = 1'b1;
    tick(2);
    n_checks++;
    if (outs !== O_CFG) begin
      n_fail++;
      $display("FAIL coincide_pre edge 84: got %b expected %b", outs, O_CFG);
    end
    tick(1);
    n_checks++;
    if (outs !== O_READY) begin
      n_fail++;
      $display("FAIL coincide_ready edge 85: got %b expected %b", outs, O_READY);
    end
    tick(5);
    n_checks++;
    if (outs !== O_READY) begin
      n_fail++;
      $display("FAIL coincide_hold: got %b expected %b", outs, O_READY);
    end
    cfg_done = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    tick(35);
    n_checks++;
    if (outs !== O_CFG) begin
      n_fail++;
      $display("FAIL no_timeout_entry: got %b expected %b", outs, O_CFG);
    end
    tick(1000);
    n_checks++;
    if (outs !== O_CFG) begin
      n_fail++;
      $display("FAIL no_timeout_hold: got %b expected %b", outs, O_CFG);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_power_up();
    test_cfg_ready();
    test_soft_restart_ready();
    test_cfg_done_ignored();
    test_async_reset();
`ifdef CAM_SEQ_TIMEOUT_EN
    test_timeout_retry();
    test_soft_restart_fail();
    test_coincide();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
